// File: rtl/omsp_spm_pkg.sv
// omsp_spm_pkg: shared command encodings and sequencer state type for SPM management
package omsp_spm_pkg;

    localparam logic [1:0] OP_PROTECT   = 2'b00;
    localparam logic [1:0] OP_UNPROTECT = 2'b01;
    localparam logic [1:0] OP_VERIFY    = 2'b10;
    localparam logic [1:0] OP_ILLEGAL   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_CHECK,
        ST_KEYREQ,
        ST_KEYWR,
        ST_CANCEL,
        ST_DISABLE,
        ST_VERIFY,
        ST_VCHECK,
        ST_DONE
    } spm_state_t;

endpackage

// File: rtl/omsp_spm_cmd_seq.sv
// omsp_spm_cmd_seq: sequences protect/unprotect/verify into SPM array strobes and key writes
module omsp_spm_cmd_seq
    import omsp_spm_pkg::*;
#(
    parameter int KEY_WORDS    = 4,
    parameter int KEY_IDX_SIZE = 2,
    parameter int KEY_TIMEOUT  = 64
) (
    input  logic                    mclk,
    input  logic                    puc_rst,
    input  logic                    cmd_valid,
    input  logic [1:0]              cmd_op,
    output logic                    cmd_ready,
    output logic                    busy,
    output logic                    update_spm,
    output logic                    enable_spm,
    output logic                    disable_spm,
    output logic                    cancel_spm,
    output logic                    verify_spm,
    input  logic                    violation,
    output logic                    key_req,
    input  logic                    key_ack,
    input  logic [15:0]             key_word,
    output logic                    write_key,
    output logic [15:0]             key_in,
    output logic [KEY_IDX_SIZE-1:0] key_idx,
    output logic                    done,
    output logic                    done_ok
);

    localparam int CW = $clog2(KEY_TIMEOUT + 1);

    spm_state_t              state;
    logic [CW-1:0]           cnt;
    logic [KEY_IDX_SIZE-1:0] idx;
    logic [15:0]             key_q;
    logic                    ok;

    // Command sequencer: state walk, key capture, index/timeout counters and result
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            key_q <= '0;
            ok    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    case (cmd_op)
                        OP_PROTECT:   state <= ST_UPDATE;
                        OP_UNPROTECT: state <= ST_DISABLE;
                        OP_VERIFY:    state <= ST_VERIFY;
                        default: begin
                            state <= ST_DONE;
                            ok    <= 1'b0;
                        end
                    endcase
                end
                ST_UPDATE: state <= ST_CHECK;
                ST_CHECK: begin
                    if (violation) state <= ST_CANCEL;
                    else begin
                        state <= ST_KEYREQ;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                end
                ST_KEYREQ: begin
                    if (key_ack) begin
                        key_q <= key_word;
                        state <= ST_KEYWR;
                    end else if (cnt == CW'(KEY_TIMEOUT - 1)) state <= ST_CANCEL;
                    else cnt <= cnt + 1'b1;
                end
                ST_KEYWR: begin
                    if (idx == KEY_IDX_SIZE'(KEY_WORDS - 1)) begin
                        state <= ST_DONE;
                        ok    <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        cnt   <= '0;
                        state <= ST_KEYREQ;
                    end
                end
                ST_CANCEL: begin
                    state <= ST_DONE;
                    ok    <= 1'b0;
                end
                ST_DISABLE: begin
                    state <= ST_DONE;
                    ok    <= 1'b1;
                end
                ST_VERIFY: state <= ST_VCHECK;
                ST_VCHECK: begin
                    state <= ST_DONE;
                    ok    <= ~violation;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are pure decodes of the registered state, so each lasts exactly one state-cycle
    always_comb begin
        cmd_ready   = state == ST_IDLE;
        busy        = state != ST_IDLE;
        update_spm  = state == ST_UPDATE || state == ST_CANCEL || state == ST_DISABLE;
        enable_spm  = state == ST_UPDATE;
        disable_spm = state == ST_DISABLE;
        cancel_spm  = state == ST_CANCEL;
        verify_spm  = state == ST_VERIFY;
        key_req     = state == ST_KEYREQ;
        write_key   = state == ST_KEYWR;
        key_in      = key_q;
        key_idx     = idx;
        done        = state == ST_DONE;
        done_ok     = state == ST_DONE && ok;
    end

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// tb_omsp_spm_cmd_seq: randomized transaction-level check of the SPM command sequencer
module tb_omsp_spm_cmd_seq;

    localparam int N  = 400;
    localparam int TO = 64;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic        violation = 1'b0;
    logic        key_ack = 1'b0;
    logic [15:0] key_word = 16'h0;
    logic        cmd_ready, busy, update_spm, enable_spm, disable_spm, cancel_spm, verify_spm;
    logic        key_req, write_key, done, done_ok;
    logic [15:0] key_in;
    logic [1:0]  key_idx;

    int checks = 0;
    int errors = 0;

    // expected per-cycle vector: {ready,busy,upd,en,dis,can,ver,kreq,wk,done,ok}
    logic [10:0] e_vec [N];
    logic [17:0] e_key [N];
    logic        a_ack [N];
    logic [15:0] a_word [N];
    int          dly [4];
    logic [15:0] wrd [4];

    omsp_spm_cmd_seq dut (
        .mclk(mclk), .puc_rst(puc_rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .busy(busy), .update_spm(update_spm), .enable_spm(enable_spm),
        .disable_spm(disable_spm), .cancel_spm(cancel_spm), .verify_spm(verify_spm),
        .violation(violation), .key_req(key_req), .key_ack(key_ack), .key_word(key_word),
        .write_key(write_key), .key_in(key_in), .key_idx(key_idx), .done(done), .done_ok(done_ok)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] obs();
        return {cmd_ready, busy, update_spm, enable_spm, disable_spm, cancel_spm, verify_spm,
                key_req, write_key, done, done_ok};
    endfunction

    // Transaction model: timeline of the command from the accept cycle (0) to the done cycle
    task automatic build(input logic [1:0] op, input logic viol, output int dn);
        int  t;
        logic ok, timed_out;
        for (int c = 0; c < N; c++) begin
            e_vec[c]  = '0;
            e_key[c]  = '0;
            a_ack[c]  = 1'b0;
            a_word[c] = 16'($urandom);
        end
        ok = 1'b0;
        dn = 1;
        if (op == 2'b00) begin
            e_vec[1][8] = 1'b1;
            e_vec[1][7] = 1'b1;
            if (viol) begin
                e_vec[3][8] = 1'b1;
                e_vec[3][5] = 1'b1;
                dn = 4;
            end else begin
                t = 3;
                timed_out = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (!timed_out) begin
                        if (dly[i] >= TO) begin
                            for (int k = 0; k < TO; k++) e_vec[t+k][3] = 1'b1;
                            e_vec[t+TO][8] = 1'b1;
                            e_vec[t+TO][5] = 1'b1;
                            dn = t + TO + 1;
                            timed_out = 1'b1;
                        end else begin
                            for (int k = 0; k <= dly[i]; k++) e_vec[t+k][3] = 1'b1;
                            a_ack[t+dly[i]]  = 1'b1;
                            a_word[t+dly[i]] = wrd[i];
                            e_vec[t+dly[i]+1][2] = 1'b1;
                            e_key[t+dly[i]+1] = {2'(i), wrd[i]};
                            t = t + dly[i] + 2;
                        end
                    end
                end
                if (!timed_out) begin
                    dn = t;
                    ok = 1'b1;
                end
            end
        end else if (op == 2'b01) begin
            e_vec[1][8] = 1'b1;
            e_vec[1][6] = 1'b1;
            dn = 2;
            ok = 1'b1;
        end else if (op == 2'b10) begin
            e_vec[1][4] = 1'b1;
            dn = 3;
            ok = !viol;
        end
        for (int c = 0; c < N; c++) begin
            e_vec[c][9]  = c >= 1 && c <= dn;
            e_vec[c][10] = !(c >= 1 && c <= dn);
            if (!e_vec[c][3]) a_ack[c] = 1'($urandom_range(0, 1));
        end
        e_vec[dn][1] = 1'b1;
        e_vec[dn][0] = ok;
    endtask

    // Drives one command from an idle cycle; abort>0 pulses puc_rst during that cycle
    task automatic run_cmd(input logic [1:0] op, input logic viol, input logic hold, input int abort);
        int dn;
        build(op, viol, dn);
        cmd_valid = 1'b1;
        cmd_op    = op;
        violation = viol;
        key_ack   = a_ack[0];
        key_word  = a_word[0];
        check($sformatf("op%0d c0", op), 32'(obs()), 32'(e_vec[0]));
        for (int c = 1; c <= dn; c++) begin
            @(posedge mclk);
            #1;
            check($sformatf("op%0d c%0d", op, c), 32'(obs()), 32'(e_vec[c]));
            if (e_vec[c][2]) check($sformatf("key c%0d", c), 32'({key_idx, key_in}), 32'(e_key[c]));
            if (c == abort) begin
                puc_rst = 1'b1;
                #1;
                check("rst_abort", 32'({obs(), key_idx, key_in}), 32'({11'b100_0000_0000, 18'h0}));
                puc_rst   = 1'b0;
                cmd_valid = 1'b0;
                @(posedge mclk);
                #1;
                return;
            end
            cmd_valid = hold && c < dn;
            cmd_op    = 2'($urandom);
            key_ack   = a_ack[c];
            key_word  = a_word[c];
        end
        cmd_valid = 1'b0;
        @(posedge mclk);
        #1;
    endtask

    function automatic int pick_dly();
        int r;
        r = $urandom_range(0, 9);
        return r < 5 ? 0 : r < 8 ? int'($urandom_range(1, 4)) : r == 8 ? TO - 1 : TO;
    endfunction

    initial begin
        #12;
        check("reset", 32'({obs(), key_idx, key_in}), 32'({11'b100_0000_0000, 18'h0}));
        puc_rst = 1'b0;
        @(posedge mclk);
        #1;
        dly = '{0, 0, 0, 0};
        wrd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        run_cmd(2'b00, 1'b0, 1'b0, 0);
        run_cmd(2'b00, 1'b1, 1'b0, 0);
        dly = '{0, TO, 0, 0};
        run_cmd(2'b00, 1'b0, 1'b0, 0);
        run_cmd(2'b01, 1'b0, 1'b0, 0);
        run_cmd(2'b10, 1'b1, 1'b0, 0);
        run_cmd(2'b10, 1'b0, 1'b0, 0);
        run_cmd(2'b11, 1'b0, 1'b0, 0);
        dly = '{0, 0, 0, 0};
        run_cmd(2'b00, 1'b0, 1'b1, 0);
        dly = '{TO - 1, 1, 2, 0};
        run_cmd(2'b00, 1'b0, 1'b1, 0);
        dly = '{5, 0, 0, 0};
        run_cmd(2'b00, 1'b0, 1'b0, 5);
        dly = '{0, 0, 0, 0};
        wrd = '{16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0001};
        run_cmd(2'b00, 1'b0, 1'b0, 0);
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                dly[i] = pick_dly();
                wrd[i] = 16'($urandom);
            end
            run_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, 1'($urandom), 0);
        end
        check("idle_end", 32'(obs()), 32'(11'b100_0000_0000));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
